// File: rtl/sensor_pkg.sv
//------------------------------------------------------------------------------
// Module   : sensor_pkg
// Purpose  : Shared constants for the sensor input-conditioning stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sensor_pkg;
   localparam int CH_ARM                  = 0;
   localparam int CH_TRIGGER              = 1;
   localparam int CH_CONFIRM              = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int EVENT_COUNT_W           = 8;
endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
//------------------------------------------------------------------------------
// Module   : debounce_channel
// Purpose  : One channel: 2-flop synchronizer, stability counter, level and
//            registered rise/fall pulses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   input  logic clear,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy,
   output logic rise_accept
);

   localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   logic w_mismatch;
   logic w_accept;

   assign w_mismatch = (r_sync2 != r_level);
   // clear overrides an accept landing on the same edge
   assign w_accept   = w_mismatch && (r_cnt == c_CNT_MAX) && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_rise <= w_accept && r_sync2;
         r_fall <= w_accept && !r_sync2;
         if (w_accept) begin
            r_level <= r_sync2;
         end
         if (clear || !w_mismatch || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level_out   = r_level;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign busy        = (r_cnt != '0);
   assign rise_accept = w_accept && r_sync2;

endmodule

`default_nettype wire

// File: rtl/sensor_debounce.sv
//------------------------------------------------------------------------------
// Module   : sensor_debounce
// Purpose  : Debounces the alarm sensor pins and counts trigger-channel rises.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sensor_debounce
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CHANNELS        = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNELS-1:0]      raw_in,
   input  logic                     clear,
   output logic [CHANNELS-1:0]      level_out,
   output logic [CHANNELS-1:0]      rise_pulse,
   output logic [CHANNELS-1:0]      fall_pulse,
   output logic                     busy,
   output logic [EVENT_COUNT_W-1:0] event_count
);

   logic [CHANNELS-1:0]      w_busy;
   logic [CHANNELS-1:0]      w_rise_accept;
   logic [EVENT_COUNT_W-1:0] r_event_count;
   logic                     w_unused;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw_in      (raw_in[i]),
            .clear       (clear),
            .level_out   (level_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .busy        (w_busy[i]),
            .rise_accept (w_rise_accept[i])
         );
      end
   endgenerate

   // Counted on the accept edge so the count moves together with rise_pulse[1]
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_event_count <= '0;
      end else if (clear) begin
         r_event_count <= '0;
      end else if (w_rise_accept[CH_TRIGGER] && (r_event_count != '1)) begin
         r_event_count <= r_event_count + 1'b1;
      end
   end

   assign busy        = |w_busy;
   assign event_count = r_event_count;
   assign w_unused    = &{1'b0, w_rise_accept};

endmodule

`default_nettype wire

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: random and directed stimulus, behavioural model
// feeding a scoreboard queue that a monitor drains every cycle.
`timescale 1ns/1ps

module tb_sensor_debounce;

   localparam int D = 4;

   typedef struct packed {
      logic [2:0] lvl;
      logic [2:0] rise;
      logic [2:0] fall;
      logic       busy;
      logic [7:0] evt;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] raw_in;
   logic       clear;
   logic [2:0] level_out;
   logic [2:0] rise_pulse;
   logic [2:0] fall_pulse;
   logic       busy;
   logic [7:0] event_count;

   int total = 0;
   int bad   = 0;
   int obs_rise1 = 0;
   int obs_fall1 = 0;

   obs_t sb[$];

   sensor_debounce #(
      .DEBOUNCE_CYCLES (D),
      .CHANNELS        (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_in      (raw_in),
      .clear       (clear),
      .level_out   (level_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .busy        (busy),
      .event_count (event_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a new level is accepted once D consecutive synchronized
   // samples disagree with the current level; any agreeing sample or clear
   // restarts the run.
   initial begin
      logic [2:0] m_s1, m_s2, m_lvl;
      int         m_run[3];
      int         m_evt;
      obs_t       e;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_evt = 0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_evt = 0;
            for (int c = 0; c < 3; c++) m_run[c] = 0;
            sb.delete();
         end else begin
            e = '0;
            for (int c = 0; c < 3; c++) begin
               if (clear || m_s2[c] == m_lvl[c]) begin
                  m_run[c] = 0;
               end else begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] == D) begin
                     m_run[c] = 0;
                     m_lvl[c] = m_s2[c];
                     if (m_s2[c]) e.rise[c] = 1'b1;
                     else         e.fall[c] = 1'b1;
                  end
               end
               if (m_run[c] != 0) e.busy = 1'b1;
            end
            if (clear)                      m_evt = 0;
            else if (e.rise[1] && m_evt < 255) m_evt = m_evt + 1;
            m_s2  = m_s1;
            m_s1  = raw_in;
            e.lvl = m_lvl;
            e.evt = 8'(m_evt);
            sb.push_back(e);
         end
      end
   end

   // Monitor: compares every settled cycle against the model's prediction.
   initial begin
      obs_t got, e;
      forever begin
         @(negedge clk);
         got = '{lvl: level_out, rise: rise_pulse, fall: fall_pulse,
                 busy: busy, evt: event_count};
         if (rise_pulse[1]) obs_rise1++;
         if (fall_pulse[1]) obs_fall1++;
         if (!rst_n) begin
            total++;
            if (got !== obs_t'('0)) begin
               bad++;
               $display("FAIL in_reset t=%0t got=%h required=0", $time, got);
            end
         end else if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL scoreboard t=%0t got lvl=%b rise=%b fall=%b busy=%b evt=%0d required lvl=%b rise=%b fall=%b busy=%b evt=%0d",
                        $time, got.lvl, got.rise, got.fall, got.busy, got.evt,
                        e.lvl, e.rise, e.fall, e.busy, e.evt);
            end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int req);
      total++;
      if (got != req) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   task automatic drive(input logic [2:0] r, input logic c, input int n);
      raw_in = r;
      clear  = c;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int r1, f1, len;
      logic [2:0] rv;
      rst_n  = 1'b0;
      raw_in = 3'b000;
      clear  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_level", int'(level_out), 0);
      chk("reset_evt", int'(event_count), 0);
      rst_n = 1'b1;

      // Held rise on channel 0: accepted on edge D+2 only
      drive(3'b001, 1'b0, D + 1);
      chk("ch0_before", int'(level_out[0]), 0);
      drive(3'b001, 1'b0, 1);
      chk("ch0_level_e6", int'(level_out[0]), 1);
      chk("ch0_rise_e6", int'(rise_pulse[0]), 1);
      drive(3'b001, 1'b0, 1);
      chk("ch0_rise_e7", int'(rise_pulse[0]), 0);

      // Glitch one sample shorter than D
      drive(3'b011, 1'b0, D - 1);
      drive(3'b001, 1'b0, 8);
      chk("glitch_level1", int'(level_out[1]), 0);
      chk("glitch_evt", int'(event_count), 0);
      chk("glitch_busy", int'(busy), 0);

      // Five clean rise/fall cycles on the trigger channel
      r1 = obs_rise1; f1 = obs_fall1;
      for (int k = 0; k < 5; k++) begin
         drive(3'b011, 1'b0, 8);
         drive(3'b001, 1'b0, 8);
      end
      chk("five_rises", obs_rise1 - r1, 5);
      chk("five_falls", obs_fall1 - f1, 5);
      chk("five_evt", int'(event_count), 5);

      for (int k = 0; k < 300; k++) begin
         drive(3'b011, 1'b0, 6);
         drive(3'b001, 1'b0, 6);
      end
      chk("evt_saturated", int'(event_count), 255);

      // clear on the accept edge of a trigger rise
      drive(3'b001, 1'b0, 4);
      drive(3'b011, 1'b0, D + 1);
      drive(3'b011, 1'b1, 1);
      chk("clr_rise1", int'(rise_pulse[1]), 0);
      chk("clr_level1", int'(level_out[1]), 0);
      chk("clr_evt", int'(event_count), 0);
      drive(3'b011, 1'b0, D - 1);
      chk("reaccept_early", int'(level_out[1]), 0);
      drive(3'b011, 1'b0, 1);
      chk("reaccept_level", int'(level_out[1]), 1);
      chk("reaccept_rise", int'(rise_pulse[1]), 1);
      chk("reaccept_evt", int'(event_count), 1);

      // Random segments with occasional single-cycle clears
      for (int k = 0; k < 80; k++) begin
         rv  = 3'($urandom_range(0, 7));
         len = $urandom_range(1, 8);
         drive(rv, ($urandom_range(0, 15) == 0), 1);
         if (len > 1) drive(rv, 1'b0, len - 1);
      end

      // Pins already high at reset release
      rst_n = 1'b0;
      drive(3'b111, 1'b0, 2);
      rst_n = 1'b1;
      drive(3'b111, 1'b0, D + 1);
      chk("rel_level_before", int'(level_out), 0);
      drive(3'b111, 1'b0, 1);
      chk("rel_level_e6", int'(level_out), 7);
      chk("rel_rise_e6", int'(rise_pulse), 7);
      drive(3'b111, 1'b0, 1);
      chk("rel_rise_e7", int'(rise_pulse), 0);

      // Asynchronous reset in the middle of a count
      drive(3'b000, 1'b0, 4);
      chk("mid_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_level", int'(level_out), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_pulses", int'({rise_pulse, fall_pulse}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      r1 = obs_rise1; f1 = obs_fall1;
      drive(3'b000, 1'b0, 10);
      chk("post_rst_pulses", (obs_rise1 - r1) + (obs_fall1 - f1), 0);
      chk("post_rst_level", int'(level_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
